lcd_bus_responder: RTL and testbench
====================================

# lcd_bus_responder

HD44780-style responder for the character-LCD bus driven by our LCD test/display drivers. It samples LCD_DATA/LCD_RS/LCD_RW on each LCD_EN strobe and decodes the instruction set. It keeps a 2x16 character buffer, cursor address and display flags, and flags strobes that violate busy time. It serves as the display model in benches and as a mirror that a video overlay can read from.

## Interface
Parameters:
- CMD_BUSY, 40: iCLK cycles oBUSY stays high after any accepted non-clear transaction.
- CLR_PAD, 1600: extra busy cycles after a clear's 32-cycle fill.

Ports:
- iCLK  in  1  sole clock.
- iRST_N  in  1  asynchronous, active-low reset.
- LCD_DATA  in  8  bus data.
- LCD_RS  in  1  1 = data, 0 = instruction.
- LCD_RW  in  1  1 = read cycle.
- LCD_EN  in  1  strobe; the transaction is taken on its falling edge.
- iRD_ADDR  in  5  buffer read index; 0-15 = line 1, 16-31 = line 2.
- oRD_DATA  out  8  buffer byte; registered, 1-cycle latency.
- oCURSOR  out  7  current DDRAM address.
- oDISP_ON, oCUR_ON, oBLINK  out  1  display-control bits D/C/B.
- oLINES2  out  1  function-set N bit.
- oBUSY  out  1  high while clearing or during the busy countdown.
- oPROTO_ERR  out  1  sticky; set when a strobe is dropped or a read cycle is seen.

## Operation
- Input capture: LCD_EN, LCD_RS, LCD_RW and LCD_DATA each pass through a 2-flop synchronizer.
- Falling-edge detect: the synchronized EN was 1 last cycle and is 0 now.
- The transaction uses RS/RW/DATA held in the last cycle that synchronized EN was 1.
- Any RW=1 strobe: sets oPROTO_ERR; no other effect.
- States: CLEAR (fill), HOLD (busy countdown), IDLE.
- CLEAR: writes 0x20 to buffer index 0..31, one per cycle. Then loads the countdown with CLR_PAD and goes to HOLD.
- HOLD: decrements the countdown and goes to IDLE at 0.
- oBUSY = (state != IDLE).
- Any strobe detected in CLEAR or HOLD is dropped and sets oPROTO_ERR.
- In IDLE, each strobe is decoded, then HOLD is entered with CMD_BUSY; clear is the only exception.
- Instruction decode (RS=0), highest set bit wins:
  - 1xxxxxxx: set DDRAM address = DATA[6:0]; target becomes DDRAM.
  - 01xxxxxx: set CGRAM address; target becomes CGRAM, so subsequent data writes are discarded, but the address still moves.
  - 001xxxxx: oLINES2 <= DATA[3].
  - 0001xxxx: cursor/display shift; no effect.
  - 00001dcb: display-control flags <= d, c, b.
  - 000001is: id <= i; s ignored.
  - 0000001x: home; address 0, target DDRAM.
  - 00000001: clear; address 0, id <= 1, target DDRAM, enter CLEAR.
  - 00000000: no-op; still enters HOLD.
- Data write (RS=1, target DDRAM):
  - Address 0x00-0x0F maps to index addr.
  - Address 0x40-0x4F maps to index 16 + addr[3:0].
  - Any other address discards the byte.
- After every data write, with either target, the address steps by id:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00; an illegal address (0x28-0x3F, 0x68-0x7F) goes to 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
- Buffer: 32x8, single write port. The CLEAR fill and the data write never coincide.
- Reset values: state CLEAR at fill index 0, oBUSY 1, oCURSOR 0, id 1, target DDRAM, oDISP_ON/oCUR_ON/oBLINK/oLINES2 0, oPROTO_ERR 0, oRD_DATA 0.
- Reset does not touch the buffer array. The post-reset CLEAR initializes it.

## Timing
- Raw LCD_EN fall to state/flag update: 3 iCLK edges (2 sync + 1 detect/apply).
- Buffer written on that same edge; oRD_DATA shows it one edge later if iRD_ADDR matches.
- oBUSY is high the edge after acceptance for exactly CMD_BUSY cycles. For clear, the duration is 32 + CLR_PAD cycles.
- After reset release, oBUSY is high for 32 + CLR_PAD cycles.
- Minimum strobe: EN high ≥ 2 iCLK and low ≥ 2 iCLK; shorter pulses may be missed, and this is not flagged.
- Reset asserted mid-CLEAR or mid-HOLD: immediate return to reset values; the fill restarts at index 0.

## Test plan
- Reset, wait 32 + CLR_PAD: oBUSY falls; all 32 oRD_DATA reads = 0x20; oCURSOR = 0.
- Instructions 0x38, 0x0C, 0x06, 0x80, then data 0x41, 0x42: oLINES2 = 1, oDISP_ON = 1, oCUR_ON = 0; index 0 = 0x41, index 1 = 0x42, oCURSOR = 0x02.
- Instruction 0xC0, data 0x5A; then 0xA7, data 0x31: index 16 = 0x5A; 0x31 discarded; oCURSOR goes 0x27 -> 0x40.
- Instruction 0x04 (decrement), 0x80, data 0x30: index 0 = 0x30, oCURSOR = 0x67. Then 0x40, data 0x55: no buffer change.
- Second strobe 10 cycles after the first (CMD_BUSY = 40): dropped; oPROTO_ERR = 1 and stays 1 until reset. An RW=1 strobe on a clean run also sets it.
- Fill buffer, send 0x01, assert iRST_N low at fill index 10, release: oBUSY = 1 for 32 + CLR_PAD; buffer all 0x20; flags at reset values.

Source files
------------

// File: rtl/lcd_bus_responder_if.sv
// Character-LCD bus plus buffer-readout signals shared by the responder and whatever drives it.
// The LCD strobe side and the mirror read port travel together.
interface lcd_bus_responder_if;
    logic [7:0] LCD_DATA;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [4:0] iRD_ADDR;
    logic [7:0] oRD_DATA;
    logic [6:0] oCURSOR;
    logic       oDISP_ON;
    logic       oCUR_ON;
    logic       oBLINK;
    logic       oLINES2;
    logic       oBUSY;
    logic       oPROTO_ERR;

    modport master (
        output LCD_DATA, LCD_RS, LCD_RW, LCD_EN, iRD_ADDR,
        input  oRD_DATA, oCURSOR, oDISP_ON, oCUR_ON, oBLINK, oLINES2, oBUSY, oPROTO_ERR
    );

    modport slave (
        input  LCD_DATA, LCD_RS, LCD_RW, LCD_EN, iRD_ADDR,
        output oRD_DATA, oCURSOR, oDISP_ON, oCUR_ON, oBLINK, oLINES2, oBUSY, oPROTO_ERR
    );
endinterface

// File: rtl/lcd_bus_responder.sv
// HD44780-style responder: decodes strobes from a character-LCD bus into a 2x16 buffer,
// cursor address and display flags, and flags strobes that break the busy window.
module lcd_bus_responder #(
    parameter int unsigned CMD_BUSY = 40,
    parameter int unsigned CLR_PAD  = 1600
) (
    input logic                 iCLK,
    input logic                 iRST_N,
    lcd_bus_responder_if.slave  bus
);

    localparam int unsigned CntMax = (CMD_BUSY > CLR_PAD) ? CMD_BUSY : CLR_PAD;
    localparam int unsigned CntW   = (CntMax > 2) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] CmdLoad = CntW'(CMD_BUSY - 1);
    localparam logic [CntW-1:0] ClrLoad = CntW'(CLR_PAD - 1);

    typedef enum logic [1:0] {StClear, StHold, StIdle} state_e;

    // Synchronizers and strobe capture
    logic [1:0] en_sync_q, rs_sync_q, rw_sync_q;
    logic [7:0] data_s1_q, data_s2_q;
    logic       en_prev_q, rs_hold_q, rw_hold_q;
    logic [7:0] data_hold_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            en_sync_q   <= '0;
            rs_sync_q   <= '0;
            rw_sync_q   <= '0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
            en_prev_q   <= 1'b0;
            rs_hold_q   <= 1'b0;
            rw_hold_q   <= 1'b0;
            data_hold_q <= '0;
        end else begin
            en_sync_q <= {en_sync_q[0], bus.LCD_EN};
            rs_sync_q <= {rs_sync_q[0], bus.LCD_RS};
            rw_sync_q <= {rw_sync_q[0], bus.LCD_RW};
            data_s1_q <= bus.LCD_DATA;
            data_s2_q <= data_s1_q;
            en_prev_q <= en_sync_q[1];
            // Keep the bus values from the last cycle EN was seen high
            if (en_sync_q[1]) begin
                rs_hold_q   <= rs_sync_q[1];
                rw_hold_q   <= rw_sync_q[1];
                data_hold_q <= data_s2_q;
            end
        end
    end

    logic strobe;
    assign strobe = en_prev_q & ~en_sync_q[1];

    state_e          state_q;
    logic [4:0]      fill_q;
    logic [CntW-1:0] cnt_q;
    logic [6:0]      addr_q;
    logic            id_q, cgram_q;
    logic            disp_q, cur_q, blink_q, lines2_q, err_q, busy_q;

    function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == 7'h27)                          r = 7'h40;
            else if (a == 7'h67)                     r = 7'h00;
            else if ((a >= 7'h28 && a <= 7'h3F) || a >= 7'h68) r = 7'h00;
            else                                     r = a + 7'd1;
        end else begin
            if (a == 7'h00)      r = 7'h67;
            else if (a == 7'h40) r = 7'h27;
            else                 r = a - 7'd1;
        end
        return r;
    endfunction

    logic accept;
    assign accept = strobe && !rw_hold_q && (state_q == StIdle);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= StClear;
            fill_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            id_q     <= 1'b1;
            cgram_q  <= 1'b0;
            disp_q   <= 1'b0;
            cur_q    <= 1'b0;
            blink_q  <= 1'b0;
            lines2_q <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            if (strobe && (rw_hold_q || state_q != StIdle)) err_q <= 1'b1;
            unique case (state_q)
                StClear: begin
                    fill_q <= fill_q + 5'd1;
                    if (fill_q == 5'd31) begin
                        cnt_q   <= ClrLoad;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StIdle: begin
                    if (accept) begin
                        state_q <= StHold;
                        cnt_q   <= CmdLoad;
                        busy_q  <= 1'b1;
                        if (rs_hold_q) begin
                            addr_q <= step_addr(addr_q, id_q);
                        end else begin
                            unique casez (data_hold_q)
                                8'b1???????: begin
                                    addr_q  <= data_hold_q[6:0];
                                    cgram_q <= 1'b0;
                                end
                                8'b01??????: begin
                                    addr_q  <= {1'b0, data_hold_q[5:0]};
                                    cgram_q <= 1'b1;
                                end
                                8'b001?????: lines2_q <= data_hold_q[3];
                                8'b0001????: ;
                                8'b00001???: begin
                                    disp_q  <= data_hold_q[2];
                                    cur_q   <= data_hold_q[1];
                                    blink_q <= data_hold_q[0];
                                end
                                8'b000001??: id_q <= data_hold_q[1];
                                8'b0000001?: begin
                                    addr_q  <= '0;
                                    cgram_q <= 1'b0;
                                end
                                8'b00000001: begin
                                    addr_q  <= '0;
                                    id_q    <= 1'b1;
                                    cgram_q <= 1'b0;
                                    fill_q  <= '0;
                                    state_q <= StClear;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Single buffer write port shared by the clear fill and data writes
    logic       mem_we;
    logic [4:0] mem_idx;
    logic [7:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = 8'h20;
        if (state_q == StClear) begin
            mem_we  = 1'b1;
            mem_idx = fill_q;
        end else if (accept && rs_hold_q && !cgram_q) begin
            mem_wdata = data_hold_q;
            if (addr_q[6:4] == 3'b000) begin
                mem_we  = 1'b1;
                mem_idx = {1'b0, addr_q[3:0]};
            end else if (addr_q[6:4] == 3'b100) begin
                mem_we  = 1'b1;
                mem_idx = {1'b1, addr_q[3:0]};
            end
        end
    end

    logic [7:0] mem_q [32];
    logic [7:0] rd_data_q;

    always_ff @(posedge iCLK) begin
        if (mem_we) mem_q[mem_idx] <= mem_wdata;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) rd_data_q <= '0;
        else         rd_data_q <= mem_q[bus.iRD_ADDR];
    end

    assign bus.oRD_DATA   = rd_data_q;
    assign bus.oCURSOR    = addr_q;
    assign bus.oDISP_ON   = disp_q;
    assign bus.oCUR_ON    = cur_q;
    assign bus.oBLINK     = blink_q;
    assign bus.oLINES2    = lines2_q;
    assign bus.oBUSY      = busy_q;
    assign bus.oPROTO_ERR = err_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder: expected buffer bytes are queued as writes are
// driven and compared when read back through the registered read port.
module tb_lcd_bus_responder;
    localparam int unsigned CMD_BUSY = 40;
    localparam int unsigned CLR_PAD  = 1600;
    localparam int          CLR_TOTAL = 32 + CLR_PAD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_bus_responder_if bus();

    lcd_bus_responder #(.CMD_BUSY(CMD_BUSY), .CLR_PAD(CLR_PAD)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] idx;
        logic [7:0] val;
    } exp_t;
    exp_t sb_q[$];

    task automatic expect_byte(input logic [4:0] idx, input logic [7:0] val);
        exp_t e;
        e.idx = idx;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain_reads(input string tag);
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            bus.iRD_ADDR = e.idx;
            @(posedge clk);
            #1;
            total++;
            if (bus.oRD_DATA !== e.val) begin
                bad++;
                $display("FAIL %s idx=%0d got=%h want=%h", tag, e.idx, bus.oRD_DATA, e.val);
            end
        end
    endtask

    task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        bus.LCD_RS   = rs;
        bus.LCD_RW   = rw;
        bus.LCD_DATA = d;
        bus.LCD_EN   = 1'b1;
        repeat (3) @(negedge clk);
        bus.LCD_EN = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (4) @(posedge clk);
        #1;
        while (bus.oBUSY && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (bus.oBUSY) begin
            bad++;
            $display("FAIL %s busy_timeout busy=%b want=0", tag, bus.oBUSY);
        end
    endtask

    task automatic cmd(input logic [7:0] d);
        strobe(1'b0, 1'b0, d);
        wait_idle("cmd");
    endtask

    task automatic wr(input logic [7:0] d);
        strobe(1'b1, 1'b0, d);
        wait_idle("wr");
    endtask

    // Releases reset on a falling clock edge and counts edges until oBUSY drops.
    task automatic release_and_count(output int n);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.oBUSY && n < 3 * CLR_TOTAL);
    endtask

    task automatic test_reset();
        int n;
        bus.LCD_EN = 1'b0;
        bus.LCD_RS = 1'b0;
        bus.LCD_RW = 1'b0;
        bus.LCD_DATA = '0;
        bus.iRD_ADDR = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({bus.oBUSY, bus.oCURSOR, bus.oDISP_ON, bus.oCUR_ON, bus.oBLINK, bus.oLINES2,
             bus.oPROTO_ERR, bus.oRD_DATA} !== {1'b1, 7'h00, 4'b0000, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL reset_vals busy=%b cur=%h d=%b c=%b b=%b n=%b err=%b rd=%h want busy=1 rest 0",
                     bus.oBUSY, bus.oCURSOR, bus.oDISP_ON, bus.oCUR_ON, bus.oBLINK, bus.oLINES2,
                     bus.oPROTO_ERR, bus.oRD_DATA);
        end
        release_and_count(n);
        total++;
        if (n != CLR_TOTAL) begin
            bad++;
            $display("FAIL reset_busy_len got=%0d want=%0d", n, CLR_TOTAL);
        end
        total++;
        if (bus.oCURSOR !== 7'h00) begin
            bad++;
            $display("FAIL reset_cursor got=%h want=00", bus.oCURSOR);
        end
        for (int i = 0; i < 32; i++) expect_byte(5'(i), 8'h20);
        drain_reads("reset_fill");
    endtask

    task automatic test_busy_timing();
        int n = 0;
        int m = 0;
        strobe(1'b0, 1'b0, 8'h00);
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.oBUSY && n < 10);
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL busy_latency got=%0d want=3", n);
        end
        do begin
            @(posedge clk);
            #1;
            m++;
        end while (bus.oBUSY && m < 200);
        total++;
        if (m != CMD_BUSY) begin
            bad++;
            $display("FAIL busy_len got=%0d want=%0d", m, CMD_BUSY);
        end
    endtask

    task automatic test_ddram_write();
        cmd(8'h38);
        cmd(8'h0C);
        cmd(8'h06);
        cmd(8'h80);
        wr(8'h41);
        expect_byte(5'd0, 8'h41);
        wr(8'h42);
        expect_byte(5'd1, 8'h42);
        expect_byte(5'd2, 8'h20);
        total++;
        if ({bus.oLINES2, bus.oDISP_ON, bus.oCUR_ON, bus.oBLINK} !== 4'b1100) begin
            bad++;
            $display("FAIL ddram_flags n=%b d=%b c=%b b=%b want 1100",
                     bus.oLINES2, bus.oDISP_ON, bus.oCUR_ON, bus.oBLINK);
        end
        total++;
        if (bus.oCURSOR !== 7'h02) begin
            bad++;
            $display("FAIL ddram_cursor got=%h want=02", bus.oCURSOR);
        end
        drain_reads("ddram");
    endtask

    task automatic test_line2_wrap();
        cmd(8'hC0);
        wr(8'h5A);
        expect_byte(5'd16, 8'h5A);
        expect_byte(5'd17, 8'h20);
        cmd(8'hA7);
        total++;
        if (bus.oCURSOR !== 7'h27) begin
            bad++;
            $display("FAIL line2_set got=%h want=27", bus.oCURSOR);
        end
        wr(8'h31);
        expect_byte(5'd7, 8'h20);
        expect_byte(5'd23, 8'h20);
        total++;
        if (bus.oCURSOR !== 7'h40) begin
            bad++;
            $display("FAIL line2_wrap got=%h want=40", bus.oCURSOR);
        end
        drain_reads("line2");
    endtask

    task automatic test_decrement_cgram();
        cmd(8'h04);
        cmd(8'h80);
        wr(8'h30);
        expect_byte(5'd0, 8'h30);
        total++;
        if (bus.oCURSOR !== 7'h67) begin
            bad++;
            $display("FAIL dec_wrap got=%h want=67", bus.oCURSOR);
        end
        cmd(8'h40);
        wr(8'h55);
        expect_byte(5'd0, 8'h30);
        expect_byte(5'd1, 8'h42);
        expect_byte(5'd16, 8'h5A);
        expect_byte(5'd31, 8'h20);
        drain_reads("cgram_discard");
        cmd(8'h06);
    endtask

    task automatic test_proto_drop();
        total++;
        if (bus.oPROTO_ERR !== 1'b0) begin
            bad++;
            $display("FAIL proto_clean got=%b want=0", bus.oPROTO_ERR);
        end
        strobe(1'b0, 1'b0, 8'h80);
        repeat (7) @(negedge clk);
        strobe(1'b1, 1'b0, 8'h77);
        wait_idle("proto");
        total++;
        if (bus.oPROTO_ERR !== 1'b1) begin
            bad++;
            $display("FAIL proto_drop got=%b want=1", bus.oPROTO_ERR);
        end
        total++;
        if (bus.oCURSOR !== 7'h00) begin
            bad++;
            $display("FAIL proto_cursor got=%h want=00", bus.oCURSOR);
        end
        expect_byte(5'd0, 8'h30);
        drain_reads("proto_buf");
        repeat (50) @(posedge clk);
        cmd(8'h0F);
        total++;
        if ({bus.oPROTO_ERR, bus.oDISP_ON, bus.oCUR_ON, bus.oBLINK} !== 4'b1111) begin
            bad++;
            $display("FAIL proto_sticky err=%b d=%b c=%b b=%b want 1111",
                     bus.oPROTO_ERR, bus.oDISP_ON, bus.oCUR_ON, bus.oBLINK);
        end
    endtask

    task automatic test_read_cycle();
        int n;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        release_and_count(n);
        total++;
        if (n != CLR_TOTAL || bus.oPROTO_ERR !== 1'b0) begin
            bad++;
            $display("FAIL rw_reset len=%0d err=%b want len=%0d err=0", n, bus.oPROTO_ERR, CLR_TOTAL);
        end
        cmd(8'h85);
        strobe(1'b0, 1'b1, 8'hC0);
        repeat (6) @(posedge clk);
        #1;
        total++;
        if ({bus.oPROTO_ERR, bus.oBUSY, bus.oCURSOR} !== {1'b1, 1'b0, 7'h05}) begin
            bad++;
            $display("FAIL rw_strobe err=%b busy=%b cur=%h want err=1 busy=0 cur=05",
                     bus.oPROTO_ERR, bus.oBUSY, bus.oCURSOR);
        end
    endtask

    task automatic test_clear_reset();
        int n;
        cmd(8'h80);
        for (int i = 0; i < 16; i++) wr(8'(8'h61 + i));
        cmd(8'hC0);
        for (int i = 0; i < 16; i++) wr(8'(8'h71 + i));
        expect_byte(5'd20, 8'h75);
        drain_reads("fill");
        cmd(8'h0F);
        cmd(8'h38);
        strobe(1'b0, 1'b0, 8'h01);
        repeat (13) @(posedge clk);
        #2;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        release_and_count(n);
        total++;
        if (n != CLR_TOTAL) begin
            bad++;
            $display("FAIL clr_rst_len got=%0d want=%0d", n, CLR_TOTAL);
        end
        total++;
        if ({bus.oCURSOR, bus.oDISP_ON, bus.oCUR_ON, bus.oBLINK, bus.oLINES2, bus.oPROTO_ERR}
            !== 12'h000) begin
            bad++;
            $display("FAIL clr_rst_flags cur=%h d=%b c=%b b=%b n=%b err=%b want all 0",
                     bus.oCURSOR, bus.oDISP_ON, bus.oCUR_ON, bus.oBLINK, bus.oLINES2,
                     bus.oPROTO_ERR);
        end
        for (int i = 0; i < 32; i++) expect_byte(5'(i), 8'h20);
        drain_reads("clr_rst_buf");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_busy_timing();
        test_ddram_write();
        test_line2_wrap();
        test_decrement_cgram();
        test_proto_drop();
        test_read_cycle();
        test_clear_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
